// File: rtl/attn_pkg.sv
// Shared definitions for the attention-core sequencer: FSM states and
// the bit layout of the 21-bit core instruction word.
package attn_pkg;

  localparam int INST_W     = 21;
  localparam int DIV_B      = 20;
  localparam int OFIFO_RD_B = 16;
  localparam int QK_ADD_LSB = 12;
  localparam int P_ADD_LSB  = 8;
  localparam int EXEC_B     = 7;
  localparam int KLD_B      = 6;
  localparam int Q_RD_B     = 5;
  localparam int Q_WR_B     = 4;
  localparam int K_RD_B     = 3;
  localparam int K_WR_B     = 2;
  localparam int P_RD_B     = 1;
  localparam int P_WR_B     = 0;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LD_Q  = 4'd1,
    S_LD_K  = 4'd2,
    S_KLOAD = 4'd3,
    S_GAP   = 4'd4,
    S_EXEC  = 4'd5,
    S_DRAIN = 4'd6,
    S_SFP   = 4'd7,
    S_DONE  = 4'd8
  } state_t;

endpackage

// File: rtl/attn_core_seq_inst_pack.sv
// Combinational packing of the individual control fields into the core
// instruction word; bits [19:17] are reserved and always zero.
module inst_pack
  import attn_pkg::*;
(
  input  logic              div,
  input  logic              ofifo_rd,
  input  logic [3:0]        qk_add,
  input  logic [3:0]        p_add,
  input  logic              execute,
  input  logic              kload,
  input  logic              q_rd,
  input  logic              q_wr,
  input  logic              k_rd,
  input  logic              k_wr,
  input  logic              p_rd,
  input  logic              p_wr,
  output logic [INST_W-1:0] inst
);

  // Place each field at its fixed bit position
  always_comb begin
    inst                      = {INST_W{1'b0}};
    inst[DIV_B]               = div;
    inst[OFIFO_RD_B]          = ofifo_rd;
    inst[QK_ADD_LSB +: 4]     = qk_add;
    inst[P_ADD_LSB +: 4]      = p_add;
    inst[EXEC_B]              = execute;
    inst[KLD_B]               = kload;
    inst[Q_RD_B]              = q_rd;
    inst[Q_WR_B]              = q_wr;
    inst[K_RD_B]              = k_rd;
    inst[K_WR_B]              = k_wr;
    inst[P_RD_B]              = p_rd;
    inst[P_WR_B]              = p_wr;
  end

endmodule

// File: rtl/attn_core_seq.sv
// Attention-core sequencer: one start runs load Q/K, K preload, execute,
// FIFO drain into psum memory and SFP normalisation, emitting a registered inst word.
module attn_core_seq
  import attn_pkg::*;
#(
  parameter int COL = 8,
  parameter int GAP = 4,
  parameter int TMO = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        len,
  input  logic              abort,
  input  logic              ld_valid,
  input  logic              fifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              ld_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [3:0]        phase
);

  localparam logic [4:0] COL_L = 5'(COL);
  localparam logic [4:0] GAP_L = 5'(GAP);
  localparam logic [7:0] TMO_L = 8'(TMO - 1);

  state_t            state;
  logic [4:0]        rows;
  logic [4:0]        cnt;
  logic [7:0]        idle;
  logic              half;
  logic [INST_W-1:0] word;

  logic f_div, f_ofifo_rd, f_execute, f_kload;
  logic f_q_rd, f_q_wr, f_k_rd, f_k_wr, f_p_rd, f_p_wr;
  logic [3:0] f_qk_add, f_p_add;

  logic last_row, last_col, last_gap;

  assign last_row = (cnt == rows - 5'd1);
  assign last_col = (cnt == COL_L - 5'd1);
  assign last_gap = (cnt == GAP_L - 5'd1);

  assign ld_ready = (state == S_LD_Q) || (state == S_LD_K);
  assign busy     = (state != S_IDLE);
  assign phase    = state;

  // Field selection for the action taken in the current state; the kernel-load
  // and execute strobes echo last cycle's k_rd/q_rd to cover SRAM read latency
  always_comb begin
    f_div      = 1'b0;
    f_ofifo_rd = 1'b0;
    f_qk_add   = 4'd0;
    f_p_add    = 4'd0;
    f_execute  = inst[Q_RD_B];
    f_kload    = inst[K_RD_B];
    f_q_rd     = 1'b0;
    f_q_wr     = 1'b0;
    f_k_rd     = 1'b0;
    f_k_wr     = 1'b0;
    f_p_rd     = 1'b0;
    f_p_wr     = 1'b0;
    case (state)
      S_LD_Q: begin
        if (ld_valid) begin
          f_q_wr   = 1'b1;
          f_qk_add = cnt[3:0];
        end else begin
          f_q_wr   = 1'b0;
        end
      end
      S_LD_K: begin
        if (ld_valid) begin
          f_k_wr   = 1'b1;
          f_qk_add = cnt[3:0];
        end else begin
          f_k_wr   = 1'b0;
        end
      end
      S_KLOAD: begin
        f_k_rd   = 1'b1;
        f_qk_add = cnt[3:0];
      end
      S_EXEC: begin
        f_q_rd   = 1'b1;
        f_qk_add = cnt[3:0];
      end
      S_DRAIN: begin
        if (fifo_valid) begin
          f_ofifo_rd = 1'b1;
          f_p_wr     = 1'b1;
          f_p_add    = cnt[3:0];
        end else begin
          f_ofifo_rd = 1'b0;
        end
      end
      S_SFP: begin
        if (!half) begin
          f_p_rd  = 1'b1;
          f_p_add = cnt[3:0];
        end else begin
          f_div   = 1'b1;
        end
      end
      default: begin
        f_div = 1'b0;
      end
    endcase
  end

  inst_pack u_pack (
    .div      (f_div),
    .ofifo_rd (f_ofifo_rd),
    .qk_add   (f_qk_add),
    .p_add    (f_p_add),
    .execute  (f_execute),
    .kload    (f_kload),
    .q_rd     (f_q_rd),
    .q_wr     (f_q_wr),
    .k_rd     (f_k_rd),
    .k_wr     (f_k_wr),
    .p_rd     (f_p_rd),
    .p_wr     (f_p_wr),
    .inst     (word)
  );

  // Sequencer state, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      rows  <= 5'd0;
      cnt   <= 5'd0;
      idle  <= 8'd0;
      half  <= 1'b0;
      inst  <= {INST_W{1'b0}};
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Clearing inst also flushes the delayed kernel-load/execute strobes
        state <= S_IDLE;
        cnt   <= 5'd0;
        idle  <= 8'd0;
        half  <= 1'b0;
        inst  <= {INST_W{1'b0}};
      end else begin
        inst <= word;
        case (state)
          S_IDLE: begin
            if (start) begin
              rows  <= {1'b0, len} + 5'd1;
              err   <= 1'b0;
              cnt   <= 5'd0;
              state <= S_LD_Q;
            end
          end
          S_LD_Q: begin
            if (ld_valid) begin
              if (last_row) begin
                cnt   <= 5'd0;
                state <= S_LD_K;
              end else begin
                cnt <= cnt + 5'd1;
              end
            end
          end
          S_LD_K: begin
            if (ld_valid) begin
              if (last_col) begin
                cnt   <= 5'd0;
                state <= S_KLOAD;
              end else begin
                cnt <= cnt + 5'd1;
              end
            end
          end
          S_KLOAD: begin
            if (last_col) begin
              cnt   <= 5'd0;
              state <= S_GAP;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          S_GAP: begin
            if (last_gap) begin
              cnt   <= 5'd0;
              state <= S_EXEC;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          S_EXEC: begin
            if (last_row) begin
              cnt   <= 5'd0;
              idle  <= 8'd0;
              state <= S_DRAIN;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          S_DRAIN: begin
            if (fifo_valid) begin
              idle <= 8'd0;
              if (last_row) begin
                cnt   <= 5'd0;
                half  <= 1'b0;
                state <= S_SFP;
              end else begin
                cnt <= cnt + 5'd1;
              end
            end else if (idle == TMO_L) begin
              err   <= 1'b1;
              cnt   <= 5'd0;
              idle  <= 8'd0;
              state <= S_IDLE;
            end else begin
              idle <= idle + 8'd1;
            end
          end
          S_SFP: begin
            if (!half) begin
              half <= 1'b1;
            end else begin
              half <= 1'b0;
              if (last_row) begin
                cnt   <= 5'd0;
                state <= S_DONE;
              end else begin
                cnt <= cnt + 5'd1;
              end
            end
          end
          S_DONE: begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_attn_core_seq.sv
// Directed self-checking bench for attn_core_seq: full-pass inst traces,
// load stalls, drain timeout, abort and asynchronous reset.
module tb_attn_core_seq;

  localparam logic [20:0] B_DIV = 21'h100000;
  localparam logic [20:0] B_OFR = 21'h010000;
  localparam logic [20:0] B_EXE = 21'h000080;
  localparam logic [20:0] B_KLD = 21'h000040;
  localparam logic [20:0] B_QRD = 21'h000020;
  localparam logic [20:0] B_QWR = 21'h000010;
  localparam logic [20:0] B_KRD = 21'h000008;
  localparam logic [20:0] B_KWR = 21'h000004;
  localparam logic [20:0] B_PRD = 21'h000002;
  localparam logic [20:0] B_PWR = 21'h000001;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  len;
  logic        abort;
  logic        ld_valid;
  logic        fifo_valid;
  logic [20:0] inst;
  logic        ld_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  phase;

  int n_checks = 0;
  int n_fail   = 0;

  attn_core_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .ld_valid   (ld_valid),
    .fifo_valid (fifo_valid),
    .inst       (inst),
    .ld_ready   (ld_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_phase(input logic [3:0] p, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (phase == p) break;
      step();
    end
    chk("wait_phase", {28'd0, phase}, {28'd0, p});
  endtask

  function automatic logic [20:0] qk(input int a);
    logic [3:0] v;
    v = 4'(a);
    return {5'd0, v, 12'd0};
  endfunction

  function automatic logic [20:0] pa(input int a);
    logic [3:0] v;
    v = 4'(a);
    return {9'd0, v, 8'd0};
  endfunction

  // One complete pass; optionally keeps start high with a different len
  // during the first cycles to show it is ignored while busy.
  task automatic run_pass(input logic [3:0] l, input bit hold_start);
    logic [20:0] exp_q[$];
    int r;
    int done_at;
    r = int'(l) + 1;
    for (int i = 0; i < r; i++) exp_q.push_back(B_QWR | qk(i));
    for (int i = 0; i < 8; i++) exp_q.push_back(B_KWR | qk(i));
    for (int i = 0; i < 8; i++) exp_q.push_back(B_KRD | qk(i) | ((i > 0) ? B_KLD : 21'd0));
    for (int i = 0; i < 4; i++) exp_q.push_back((i == 0) ? B_KLD : 21'd0);
    for (int i = 0; i < r; i++) exp_q.push_back(B_QRD | qk(i) | ((i > 0) ? B_EXE : 21'd0));
    for (int i = 0; i < r; i++) exp_q.push_back(B_OFR | B_PWR | pa(i) | ((i == 0) ? B_EXE : 21'd0));
    for (int i = 0; i < r; i++) begin
      exp_q.push_back(B_PRD | pa(i));
      exp_q.push_back(B_DIV);
    end
    exp_q.push_back(21'd0);

    len = l; start = 1'b1; ld_valid = 1'b1; fifo_valid = 1'b1;
    step();
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_ldready", {31'd0, ld_ready}, 32'd1);
    if (hold_start) len = 4'hF;
    else start = 1'b0;
    done_at = -1;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k >= 10) start = 1'b0;
      step();
      chk($sformatf("inst_c%0d", k + 1), {11'd0, inst}, {11'd0, exp_q[k]});
      chk($sformatf("done_c%0d", k + 1), {31'd0, done}, (k == exp_q.size() - 1) ? 32'd1 : 32'd0);
      if (done && done_at < 0) done_at = k + 1;
    end
    chk("pass_cycles", done_at, 5 * r + 21);
    chk("pass_idle", {31'd0, busy}, 32'd0);
    chk("pass_err", {31'd0, err}, 32'd0);
    start = 1'b0;
  endtask

  initial begin
    int nwr;
    logic exp_wr;
    reset = 1'b1; start = 1'b0; len = 4'd0; abort = 1'b0;
    ld_valid = 1'b0; fifo_valid = 1'b0;
    step(); step();
    chk("rst_inst", {11'd0, inst}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_phase", {28'd0, phase}, 32'd0);
    reset = 1'b0;
    step();

    // Nominal pass, len=3, with start held high while busy
    run_pass(4'd3, 1'b1);
    // Longest pass, addresses reach 15
    run_pass(4'd15, 1'b0);

    // ld_valid toggling in LD_Q: writes only on valid cycles
    len = 4'd3; start = 1'b1; ld_valid = 1'b0; fifo_valid = 1'b0;
    step();
    start = 1'b0;
    nwr = 0;
    for (int k = 0; k < 8; k++) begin
      exp_wr = (k % 2 == 0);
      ld_valid = exp_wr;
      step();
      chk($sformatf("tog_qwr%0d", k), {31'd0, inst[4]}, {31'd0, exp_wr});
      if (inst[4]) begin
        chk($sformatf("tog_addr%0d", k), {28'd0, inst[15:12]}, nwr);
        nwr++;
      end
    end
    chk("tog_count", nwr, 4);
    chk("tog_phase", {28'd0, phase}, 32'd2);
    abort = 1'b1; step(); abort = 1'b0;
    chk("tog_abort_idle", {31'd0, busy}, 32'd0);

    // Abort in EXEC cycle 2
    len = 4'd3; start = 1'b1; ld_valid = 1'b1; fifo_valid = 1'b0;
    step();
    start = 1'b0;
    wait_phase(4'd5, 60);
    step();
    chk("ab_exec1", {11'd0, inst}, {11'd0, B_QRD | qk(0)});
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_inst", {11'd0, inst}, 32'd0);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    step();
    chk("ab_nostray", {11'd0, inst}, 32'd0);
    chk("ab_nodone", {31'd0, done}, 32'd0);

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("sa_idle", {31'd0, busy}, 32'd0);

    // Drain timeout
    len = 4'd0; start = 1'b1; ld_valid = 1'b1; fifo_valid = 1'b0;
    step();
    start = 1'b0;
    wait_phase(4'd6, 60);
    for (int k = 0; k < 254; k++) begin
      step();
      if (done) chk("tmo_early_done", {31'd0, done}, 32'd0);
    end
    chk("tmo_err_before", {31'd0, err}, 32'd0);
    chk("tmo_busy_before", {31'd0, busy}, 32'd1);
    step();
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_idle", {31'd0, busy}, 32'd0);
    chk("tmo_nodone", {31'd0, done}, 32'd0);
    step();
    chk("tmo_sticky", {31'd0, err}, 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("tmo_clear", {31'd0, err}, 32'd0);
    abort = 1'b1; step(); abort = 1'b0;

    // Asynchronous reset mid-KLOAD
    len = 4'd1; start = 1'b1; ld_valid = 1'b1;
    step();
    start = 1'b0;
    wait_phase(4'd3, 40);
    step(); step();
    chk("kl_active", {31'd0, inst[3]}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_inst", {11'd0, inst}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_ldready", {31'd0, ld_ready}, 32'd0);
    chk("ar_phase", {28'd0, phase}, 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("ar_stay_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
